// File: rtl/detect_scheduler.sv
// Round-robin front end sharing one serial Moore "1101" detector between two
// requesters: latches a word, clears the detector, shifts MSB-first, counts hits.
//
// Ports:
//   clk, reset        clock; asynchronous active-low reset
//   req0/req1         requests, held until the matching ack
//   data0/data1       W-bit words, sampled at grant
//   ack0/ack1         one-cycle done pulses
//   det_x, det_rst_n  serial bit and active-low reset to the detector
//   det_y             detector found output (Moore, one cycle behind det_x)
//   hits, hit_flag    found count of the last completed word, and hits != 0
//   owner, busy       current/last grantee; FSM not idle
module detect_scheduler #(
  parameter int W  = 8,
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req0,
  input  logic [W-1:0]  data0,
  output logic          ack0,
  input  logic          req1,
  input  logic [W-1:0]  data1,
  output logic          ack1,
  output logic          det_x,
  output logic          det_rst_n,
  input  logic          det_y,
  output logic [CW-1:0] hits,
  output logic          hit_flag,
  output logic          owner,
  output logic          busy
);

  localparam int BW = $clog2(W);

  typedef enum logic [2:0] {
    IDLE,
    CLR,
    SHIFT,
    DRAIN,
    DONE
  } state_t;

  state_t        state, state_n;
  logic [W-1:0]  shreg, shreg_n;
  logic [BW-1:0] bitcnt, bitcnt_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          last_grant, last_n;
  logic          grant;

  logic          ack0_n, ack1_n;
  logic          det_x_n, det_rst_n_n;
  logic [CW-1:0] hits_n;
  logic          flag_n, owner_n, busy_n;

  function automatic logic [CW-1:0] sat_inc(
    input logic [CW-1:0] c,
    input logic          y
  );
    return (y && (c != {CW{1'b1}})) ? c + CW'(1) : c;
  endfunction

  // Contended grant goes to whoever did not win last time.
  always_comb begin
    grant = 1'b0;
    unique case (1'b1)
      req0 && req1:  grant = ~last_grant;
      !req0 && req1: grant = 1'b1;
      default:       grant = 1'b0;
    endcase
  end

  // Outputs are registered, so each branch computes
  // the values seen during the *next* state.
  always_comb begin
    state_n     = state;
    shreg_n     = shreg;
    bitcnt_n    = bitcnt;
    cnt_n       = cnt;
    last_n      = last_grant;
    owner_n     = owner;
    hits_n      = hits;
    flag_n      = hit_flag;
    ack0_n      = 1'b0;
    ack1_n      = 1'b0;
    det_x_n     = 1'b0;
    det_rst_n_n = 1'b1;
    unique case (state)
      IDLE: begin
        if (req0 || req1) begin
          state_n     = CLR;
          shreg_n     = grant ? data1 : data0;
          owner_n     = grant;
          last_n      = grant;
          det_rst_n_n = 1'b0;
        end
      end
      CLR: begin
        state_n  = SHIFT;
        cnt_n    = '0;
        bitcnt_n = '0;
        det_x_n  = shreg[W-1];
        shreg_n  = shreg << 1;
      end
      SHIFT: begin
        // At bitcnt 0 det_y still shows the cleared detector.
        if (bitcnt != '0) cnt_n = sat_inc(cnt, det_y);
        if (bitcnt == BW'(W-1)) begin
          state_n = DRAIN;
        end else begin
          bitcnt_n = bitcnt + BW'(1);
          det_x_n  = shreg[W-1];
          shreg_n  = shreg << 1;
        end
      end
      DRAIN: begin
        // det_y now reflects the last bit of the word.
        cnt_n   = sat_inc(cnt, det_y);
        state_n = DONE;
        hits_n  = cnt_n;
        flag_n  = (cnt_n != '0);
        ack0_n  = ~owner;
        ack1_n  = owner;
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
    busy_n = (state_n != IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      shreg      <= '0;
      bitcnt     <= '0;
      cnt        <= '0;
      last_grant <= 1'b1;
      ack0       <= 1'b0;
      ack1       <= 1'b0;
      det_x      <= 1'b0;
      det_rst_n  <= 1'b0;
      hits       <= '0;
      hit_flag   <= 1'b0;
      owner      <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_n;
      shreg      <= shreg_n;
      bitcnt     <= bitcnt_n;
      cnt        <= cnt_n;
      last_grant <= last_n;
      ack0       <= ack0_n;
      ack1       <= ack1_n;
      det_x      <= det_x_n;
      det_rst_n  <= det_rst_n_n;
      hits       <= hits_n;
      hit_flag   <= flag_n;
      owner      <= owner_n;
      busy       <= busy_n;
    end
  end

endmodule
